// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS_DFLT = 8;
   localparam int unsigned UART_SYNC_STAGES_DFLT = 2;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Received-byte channel of uart_rx_fsm: valid/ready byte plus error pulses.
// parity_err_o is present only when UART_RX_PARITY_EN is defined.
interface uart_rx_fsm_if
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = UART_DATA_BITS_DFLT
) ();

   logic [DATA_BITS-1:0] data_o;
   logic                 valid_o;
   logic                 ready_i;
   logic                 frame_err_o;
   logic                 overrun_o;
`ifdef UART_RX_PARITY_EN
   logic                 parity_err_o;

   modport master (
      output data_o, valid_o, frame_err_o, overrun_o, parity_err_o,
      input  ready_i
   );

   modport slave (
      input  data_o, valid_o, frame_err_o, overrun_o, parity_err_o,
      output ready_i
   );
`else
   modport master (
      output data_o, valid_o, frame_err_o, overrun_o,
      input  ready_i
   );

   modport slave (
      input  data_o, valid_o, frame_err_o, overrun_o,
      output ready_i
   );
`endif

endinterface

// File: rtl/rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx line plus falling-edge detect.
module rx_sync
   import uart_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = UART_SYNC_STAGES_DFLT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_rx,
   output logic o_sync,
   output logic o_fall_c
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   // Line idles high, so reset to 1 to avoid a false start edge after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '1;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_sync   = r_sync[SYNC_STAGES-1];
   assign o_fall_c = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive framer: start detect, mid-bit sampling, LSB-first deserialise,
// stop check and valid/ready delivery. Optional parity: define UART_RX_PARITY_EN.
module uart_rx_fsm
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS   = UART_DATA_BITS_DFLT,
   parameter int unsigned SYNC_STAGES = UART_SYNC_STAGES_DFLT
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit          PARITY_ODD  = 1'b0
`endif
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_i,
   input  logic          baud_tick_i,
   output logic          baud_ena_o,
   uart_rx_fsm_if.master rx_bus
);

   localparam int unsigned CNT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   logic w_sync;
   logic w_fall;

   rx_state_t            r_state;
   logic                 r_baud_ena;
   logic [CNT_W-1:0]     r_bit_cnt;
   logic [DATA_BITS-1:0] r_shreg;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_frame_err;
   logic                 r_overrun;
`ifdef UART_RX_PARITY_EN
   logic                 r_par_bad;
   logic                 r_parity_err;
`endif

   rx_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rx_sync (
      .clk      (clk),
      .rst      (rst),
      .i_rx     (rx_i),
      .o_sync   (w_sync),
      .o_fall_c (w_fall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= RX_IDLE;
         r_baud_ena  <= 1'b0;
         r_bit_cnt   <= '0;
         r_shreg     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         // Consumer handshake; a delivery in the same cycle overrides below
         if (r_valid && rx_bus.ready_i) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            RX_IDLE: begin
               if (w_fall) begin
                  r_state    <= RX_START;
                  r_baud_ena <= 1'b1;
               end
            end

            RX_START: begin
               if (baud_tick_i) begin
                  if (!w_sync) begin
                     r_state   <= RX_DATA;
                     r_bit_cnt <= '0;
                  end else begin
                     r_state    <= RX_IDLE;
                     r_baud_ena <= 1'b0;
                  end
               end
            end

            RX_DATA: begin
               if (baud_tick_i) begin
                  r_shreg   <= {w_sync, r_shreg[DATA_BITS-1:1]};
                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= RX_PARITY;
`else
                     r_state <= RX_STOP;
`endif
                  end
               end
            end

`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
               if (baud_tick_i) begin
                  r_par_bad <= (^r_shreg) ^ w_sync ^ PARITY_ODD;
                  r_state   <= RX_STOP;
               end
            end
`endif

            RX_STOP: begin
               if (baud_tick_i) begin
                  r_state    <= RX_IDLE;
                  r_baud_ena <= 1'b0;
`ifdef UART_RX_PARITY_EN
                  r_parity_err <= r_par_bad;
`endif
                  if (w_sync) begin
                     // Holding register free or being drained this cycle
                     if (!r_valid || rx_bus.ready_i) begin
                        r_data  <= r_shreg;
                        r_valid <= 1'b1;
                     end else begin
                        r_overrun <= 1'b1;
                     end
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end
            end

            default: begin
               r_state    <= RX_IDLE;
               r_baud_ena <= 1'b0;
            end
         endcase
      end
   end

   assign baud_ena_o         = r_baud_ena;
   assign rx_bus.data_o      = r_data;
   assign rx_bus.valid_o     = r_valid;
   assign rx_bus.frame_err_o = r_frame_err;
   assign rx_bus.overrun_o   = r_overrun;
`ifdef UART_RX_PARITY_EN
   assign rx_bus.parity_err_o = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: directed frames plus randomized traffic against a
// frame-level timing model of the receiver paired with a 16 clk/bit baud source.
module tb_uart_rx_fsm;

   localparam int unsigned DB       = 8;
   localparam int unsigned BIT_CLKS = 16;
   localparam bit          P_ODD    = 1'b0;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned NB = DB + 1;
`else
   localparam int unsigned NB = DB;
`endif
   // Edge offsets from the cycle rx falls: 2 sync flops + edge flop, then half a bit
   localparam int unsigned T_ENA   = 3;
   localparam int unsigned T_FIRST = T_ENA + BIT_CLKS / 2;
   localparam int unsigned T_STOP  = T_FIRST + BIT_CLKS * (NB + 1);
   localparam int unsigned EXP_ENA_CYC = T_STOP - T_ENA;

   typedef struct {
      int unsigned   s;
      logic [DB-1:0] b;
      bit            stop;
      bit            glitch;
      bit            par;
   } frm_t;

   logic clk = 1'b0;
   logic rst;
   logic rx;
   logic tick;
   logic ena;

   uart_rx_fsm_if #(.DATA_BITS(DB)) bus ();

   uart_rx_fsm #(.DATA_BITS(DB)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_i        (rx),
      .baud_tick_i (tick),
      .baud_ena_o  (ena),
      .rx_bus      (bus)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Baud source: first tick half a bit after enable, then every bit
   int unsigned bg_cnt = 0;
   always @(posedge clk) bg_cnt <= (ena === 1'b1) ? bg_cnt + 1 : 0;
   assign tick = (ena === 1'b1) && ((bg_cnt % BIT_CLKS) == (BIT_CLKS / 2 - 1));

   int unsigned n_checks = 0;
   int unsigned n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit good_par(input logic [DB-1:0] b);
      return (^b) ^ P_ODD;
   endfunction

   // Behavioural model: frame outcomes resolved at fixed edge offsets from the start
   frm_t          fq[$];
   bit            m_valid, m_ferr, m_ovr, m_perr, m_ena;
   logic [DB-1:0] m_data = '0;

   initial begin : model
      int unsigned e;
      bit rdy, dlv;
      frm_t f;
      forever begin
         @(posedge clk);
         e = cyc + 1;
         m_ferr = 1'b0;
         m_ovr  = 1'b0;
         m_perr = 1'b0;
         if (rst === 1'b1) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_ena   = 1'b0;
            fq.delete();
         end else begin
            rdy = (bus.ready_i === 1'b1);
            dlv = 1'b0;
            for (int i = 0; i < fq.size(); i++) begin
               f = fq[i];
               if (e == f.s + T_ENA) m_ena = 1'b1;
               if (f.glitch && e == f.s + T_FIRST) m_ena = 1'b0;
               if (!f.glitch && e == f.s + T_STOP) begin
                  m_ena  = 1'b0;
                  m_perr = f.par ^ good_par(f.b);
                  if (f.stop) begin
                     if (!m_valid || rdy) begin
                        m_data  = f.b;
                        m_valid = 1'b1;
                        dlv     = 1'b1;
                     end else begin
                        m_ovr = 1'b1;
                     end
                  end else begin
                     m_ferr = 1'b1;
                  end
               end
            end
            if (m_valid && rdy && !dlv) m_valid = 1'b0;
            while (fq.size() > 0 && e >= fq[0].s + (fq[0].glitch ? T_FIRST : T_STOP))
               fq.delete(0);
         end
      end
   end

   // Per-cycle compare plus event counters used by the directed checks
   bit            cmp_en = 1'b0;
   int unsigned   mon_valid_cyc = 0, mon_acc = 0, mon_ferr = 0, mon_ovr = 0, mon_perr = 0, mon_ena_cyc = 0;
   logic [DB-1:0] mon_last = '0;

   initial begin : cmp
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            chk("valid_o", 32'(bus.valid_o), 32'(m_valid));
            chk("data_o", 32'(bus.data_o), 32'(m_data));
            chk("frame_err_o", 32'(bus.frame_err_o), 32'(m_ferr));
            chk("overrun_o", 32'(bus.overrun_o), 32'(m_ovr));
            chk("baud_ena_o", 32'(ena), 32'(m_ena));
`ifdef UART_RX_PARITY_EN
            chk("parity_err_o", 32'(bus.parity_err_o), 32'(m_perr));
            if (bus.parity_err_o === 1'b1) mon_perr++;
`endif
         end
         if (bus.valid_o === 1'b1) mon_valid_cyc++;
         if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
            mon_acc++;
            mon_last = bus.data_o;
         end
         if (bus.frame_err_o === 1'b1) mon_ferr++;
         if (bus.overrun_o === 1'b1) mon_ovr++;
         if (ena === 1'b1) mon_ena_cyc++;
      end
   end

   // Sole driver of ready_i, updated just after each edge
   bit main_ready = 1'b0;
   bit rnd_rdy = 1'b0;
   initial begin : rdy_drv
      bus.ready_i = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         bus.ready_i = rnd_rdy ? ($urandom_range(0, 3) != 0) : main_ready;
      end
   end

   initial begin : watchdog
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: got cycle %0d, expected finish before 90000", cyc);
      $fatal(1, "watchdog expired");
   end

   int unsigned n_started = 0;
   int unsigned b_valid, b_acc, b_ferr, b_ovr, b_perr, b_ena;

   task automatic snap();
      b_valid = mon_valid_cyc;
      b_acc   = mon_acc;
      b_ferr  = mon_ferr;
      b_ovr   = mon_ovr;
      b_perr  = mon_perr;
      b_ena   = mon_ena_cyc;
   endtask

   task automatic tick_n(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [DB-1:0] b, input bit stop_b, input bit par_b);
      frm_t f;
      @(posedge clk);
      #1;
      f.s = cyc; f.b = b; f.stop = stop_b; f.glitch = 1'b0; f.par = par_b;
      fq.push_back(f);
      n_started++;
      rx = 1'b0;
      tick_n(BIT_CLKS);
      for (int i = 0; i < DB; i++) begin
         rx = b[i];
         tick_n(BIT_CLKS);
      end
`ifdef UART_RX_PARITY_EN
      rx = par_b;
      tick_n(BIT_CLKS);
`endif
      rx = stop_b;
      tick_n(BIT_CLKS);
      rx = 1'b1;
   endtask

   task automatic send_glitch();
      frm_t f;
      @(posedge clk);
      #1;
      f.s = cyc; f.b = '0; f.stop = 1'b1; f.glitch = 1'b1; f.par = 1'b0;
      fq.push_back(f);
      n_started++;
      rx = 1'b0;
      tick_n(3);
      rx = 1'b1;
      tick_n(24);
   endtask

   int unsigned   w, n0, gap, r;
   logic [DB-1:0] rb;
   bit            rstop, rpar;

   initial begin : main
      rx  = 1'b1;
      rst = 1'b1;
      tick_n(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 32'(bus.valid_o), 32'h0);
      chk("rst_data", 32'(bus.data_o), 32'h0);
      chk("rst_frame_err", 32'(bus.frame_err_o), 32'h0);
      chk("rst_overrun", 32'(bus.overrun_o), 32'h0);
      chk("rst_baud_ena", 32'(ena), 32'h0);
      cmp_en = 1'b1;
      tick_n(5);

      // 0x55 with consumer always ready
      main_ready = 1'b1;
      snap();
      send_frame(8'h55, 1'b1, good_par(8'h55));
      tick_n(8);
      @(negedge clk);
      chk("b55_accepts", 32'(mon_acc - b_acc), 32'd1);
      chk("b55_data", 32'(mon_last), 32'h55);
      chk("b55_valid_cycles", 32'(mon_valid_cyc - b_valid), 32'd1);
      chk("b55_ena_cycles", 32'(mon_ena_cyc - b_ena), 32'(EXP_ENA_CYC));
      chk("b55_ena_after", 32'(ena), 32'h0);
      tick_n(2);

      // Short low glitch on idle line
      snap();
      send_glitch();
      tick_n(5);
      @(negedge clk);
      chk("glitch_valid_cycles", 32'(mon_valid_cyc - b_valid), 32'd0);
      chk("glitch_frame_err", 32'(mon_ferr - b_ferr), 32'd0);
      chk("glitch_ena_cycles", 32'(mon_ena_cyc - b_ena), 32'd8);
      chk("glitch_ena_after", 32'(ena), 32'h0);
      tick_n(2);

      // 0xA3 with a low stop bit
      snap();
      send_frame(8'hA3, 1'b0, good_par(8'hA3));
      tick_n(20);
      @(negedge clk);
      chk("ferr_pulses", 32'(mon_ferr - b_ferr), 32'd1);
      chk("ferr_valid_cycles", 32'(mon_valid_cyc - b_valid), 32'd0);
      tick_n(2);

      // 0x12 then 0x34 back-to-back, consumer stalled
      main_ready = 1'b0;
      snap();
      send_frame(8'h12, 1'b1, good_par(8'h12));
      send_frame(8'h34, 1'b1, good_par(8'h34));
      tick_n(4);
      @(negedge clk);
      chk("ovr_data_held", 32'(bus.data_o), 32'h12);
      chk("ovr_valid", 32'(bus.valid_o), 32'h1);
      chk("ovr_pulses", 32'(mon_ovr - b_ovr), 32'd1);
      tick_n(1);
      main_ready = 1'b1;
      tick_n(2);
      main_ready = 1'b0;
      tick_n(2);

      // Same pair, ready pulsed in the delivery cycle of 0x34
      snap();
      n0 = n_started;
      w  = 0;
      fork
         begin
            send_frame(8'h12, 1'b1, good_par(8'h12));
            send_frame(8'h34, 1'b1, good_par(8'h34));
         end
         begin
            while (n_started < n0 + 2 && w < 1000) begin
               @(posedge clk);
               #2;
               w++;
            end
            if (w < 1000) begin
               repeat (T_STOP - 1) @(posedge clk);
               #1;
               main_ready = 1'b1;
               @(posedge clk);
               #1;
               main_ready = 1'b0;
            end
         end
      join
      chk("swap_wait_bound", 32'(w < 1000), 32'h1);
      tick_n(4);
      @(negedge clk);
      chk("swap_data", 32'(bus.data_o), 32'h34);
      chk("swap_valid", 32'(bus.valid_o), 32'h1);
      chk("swap_overrun", 32'(mon_ovr - b_ovr), 32'd0);
      chk("swap_accepts", 32'(mon_acc - b_acc), 32'd1);
      tick_n(1);
      main_ready = 1'b1;
      tick_n(2);

      // Reset in the middle of 0xFF, then a clean 0x0F
      fork
         send_frame(8'hFF, 1'b1, good_par(8'hFF));
         begin
            tick_n(70);
            rst = 1'b1;
            tick_n(2);
            rst = 1'b0;
         end
      join
      tick_n(2);
      @(negedge clk);
      chk("mrst_data", 32'(bus.data_o), 32'h0);
      chk("mrst_valid", 32'(bus.valid_o), 32'h0);
      chk("mrst_ena", 32'(ena), 32'h0);
      tick_n(1);
      snap();
      send_frame(8'h0F, 1'b1, good_par(8'h0F));
      tick_n(8);
      @(negedge clk);
      chk("post_rst_accepts", 32'(mon_acc - b_acc), 32'd1);
      chk("post_rst_data", 32'(mon_last), 32'h0F);
      tick_n(2);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones; parity bit 0 is wrong for even parity
      snap();
      send_frame(8'h07, 1'b1, 1'b0);
      tick_n(8);
      @(negedge clk);
      chk("par_err_pulses", 32'(mon_perr - b_perr), 32'd1);
      chk("par_data", 32'(mon_last), 32'h07);
      chk("par_accepts", 32'(mon_acc - b_acc), 32'd1);
      tick_n(2);
`endif

      // Randomized traffic with random consumer back-pressure
      rnd_rdy = 1'b1;
      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 7);
         if (r == 0) begin
            send_glitch();
            tick_n($urandom_range(0, 10));
         end else begin
            rb    = DB'($urandom);
            rstop = (r != 1);
            rpar  = ($urandom_range(0, 3) == 0) ? ~good_par(rb) : good_par(rb);
            send_frame(rb, rstop, rpar);
            gap = $urandom_range(0, 20) + (rstop ? 0 : BIT_CLKS);
            tick_n(gap);
         end
      end
      rnd_rdy    = 1'b0;
      main_ready = 1'b1;
      tick_n(40);
      @(negedge clk);
      chk("final_valid", 32'(bus.valid_o), 32'h0);
      chk("final_ena", 32'(ena), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
